// File: rtl/stream_mux.sv
// stream_mux: N-channel to 1 streaming multiplexer with valid/ready handshakes
// and a registered output stage.
//
// Channel selection is by the `sel` input (fixed mode). When the build defines
// STREAM_MUX_RR_EN, a round-robin arbiter and its priority pointer are also
// compiled in, and mode=1 selects round-robin. Without the macro, `mode` is
// ignored and the block is fixed-select only.
//
// in_ready is combinational from grant and output occupancy. In round-robin
// mode this adds a combinational in_valid -> in_ready path.
module stream_mux #(
  parameter int N_CH = 4,
  parameter int DW   = 8,
  localparam int SELW = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N_CH-1:0]      in_valid,
  input  logic [N_CH*DW-1:0]   in_data,
  output logic [N_CH-1:0]      in_ready,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready,
  output logic                 sel_err
);

  // N_CH expressed at SELW+1 bits so sel can be range-checked even when
  // N_CH is a power of two and does not fit in SELW bits.
  localparam logic [SELW:0] N_CH_W = N_CH[SELW:0];

  logic            mode_eff;
  logic            sel_oob;
  logic [N_CH-1:0] fixed_grant;
  logic [N_CH-1:0] rr_grant;
  logic [N_CH-1:0] grant;
  logic            load;
  logic            xfer;
  logic [SELW-1:0] grant_ch;
  logic [DW-1:0]   grant_data;

`ifdef STREAM_MUX_RR_EN
  logic [SELW-1:0] ptr;
  logic            rr_found;

  assign mode_eff = mode;

  // Round-robin grant: first valid channel strictly above ptr, else the
  // lowest valid channel (wrap-around).
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!rr_found && in_valid[i] && (SELW'(i) > ptr)) begin
        rr_grant[i] = 1'b1;
        rr_found    = 1'b1;
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (!rr_found && in_valid[i]) begin
        rr_grant[i] = 1'b1;
        rr_found    = 1'b1;
      end
    end
  end

  // Priority pointer follows the last round-robin winner; fixed-mode
  // transfers leave it alone. Reset value gives channel 0 first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= SELW'(N_CH - 1);
    end else if (mode_eff && xfer) begin
      ptr <= grant_ch;
    end
  end
`else
  logic unused_mode;

  assign mode_eff    = 1'b0;
  assign unused_mode = mode;
  assign rr_grant    = '0;
`endif

  assign sel_oob = ({1'b0, sel} >= N_CH_W);

  // Fixed-select grant: one-hot of sel; an out-of-range sel matches nothing.
  always_comb begin
    fixed_grant = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel == SELW'(i)) begin
        fixed_grant[i] = 1'b1;
      end
    end
  end

  assign grant = mode_eff ? rr_grant : fixed_grant;

  // The output register can take a word when empty or being consumed.
  // Ready is also held low while reset is asserted so producers never see
  // a handshake that the register cannot capture.
  assign load     = ~out_valid | out_ready;
  assign in_ready = grant & {N_CH{load & rst_n}};
  assign xfer     = |(in_valid & in_ready);

  // Encode the granted channel index and pick its data word.
  always_comb begin
    grant_ch   = '0;
    grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        grant_ch   = SELW'(i);
        grant_data = in_data[i*DW +: DW];
      end
    end
  end

  // Output register: load on transfer, drain when consumed with nothing new,
  // hold everything while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_ch    <= grant_ch;
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

  // Out-of-range select flag, registered every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= ~mode_eff & sel_oob;
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux: scoreboard of expected output words filled by a
// behavioural model at stimulus time, popped by an independent monitor.
module tb_stream_mux;

  localparam int N = 4;

`ifdef STREAM_MUX_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        sel_err;

  logic        mode3 = 1'b0;
  logic [1:0]  sel3 = 2'd0;
  logic [2:0]  in_valid3 = 3'b000;
  logic [23:0] in_data3 = 24'h0;
  logic        out_ready3 = 1'b1;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        sel_err3;

  always #5 clk = ~clk;

  stream_mux #(.N_CH(4), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready), .sel_err(sel_err)
  );

  stream_mux #(.N_CH(3), .DW(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
    .out_ready(out_ready3), .sel_err(sel_err3)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, got, exp, $time);
  endtask

  typedef struct {
    int d;
    int ch;
  } word_t;

  word_t exp_q[$];
  word_t last_word = '{0, 0};
  int    m_occ = 0;
  int    m_last = N - 1;
  int    m_sel_err = 0;

  // Channel chosen by the rules: sel in fixed mode, else first valid channel
  // after the last round-robin winner, wrapping. -1 means no grant.
  function automatic int pick(input bit md, input int s, input logic [3:0] v, input int last);
    if (!md) return (s < N) ? s : -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Evaluated after the inputs for the coming edge have settled.
  task automatic model_step();
    bit         md;
    int         g;
    bit         can_load;
    logic [3:0] er;
    md       = RR && mode;
    g        = pick(md, int'(sel), in_valid, m_last);
    can_load = (m_occ == 0) || out_ready;
    er       = 4'b0000;
    if (g >= 0 && can_load) er = 4'b0001 << g;
    chk("in_ready", 32'(in_ready), 32'(er));
    if (g >= 0 && can_load && in_valid[g]) begin
      exp_q.push_back('{int'(in_data[g*8 +: 8]), g});
      m_occ = 1;
      if (md) m_last = g;
    end else if (can_load) begin
      m_occ = 0;
    end
    m_sel_err = (!md && int'(sel) >= N) ? 1 : 0;
  endtask

  task automatic cycle(input bit md, input int s, input logic [3:0] v,
                       input logic [31:0] d, input bit r);
    @(negedge clk);
    mode      = md;
    sel       = 2'(s);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    model_step();
  endtask

  // Monitor: a handshake seen before an edge means a new word must appear
  // after it; otherwise a valid output must be unchanged.
  initial begin
    bit hs;
    word_t w;
    forever begin
      @(negedge clk);
      #2;
      hs = rst_n && (|(in_valid & in_ready));
      @(posedge clk);
      #2;
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'd1, 32'd0);
        end else begin
          w = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(w.d));
          chk("out_ch", 32'(out_ch), 32'(w.ch));
          last_word = w;
        end
      end else if (out_valid) begin
        chk("hold_data", 32'(out_data), 32'(last_word.d));
        chk("hold_ch", 32'(out_ch), 32'(last_word.ch));
      end
      chk("out_valid", 32'(out_valid), 32'(m_occ));
      chk("sel_err", 32'(sel_err), 32'(m_sel_err));
    end
  end

  localparam logic [31:0] D0 = 32'h44332211;

  initial begin
    mode = 1'b0; sel = 2'd2; in_valid = 4'hF; in_data = D0; out_ready = 1'b1;

    // Reset with activity on the inputs.
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    #10;
    chk("rst_in_ready2", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'h4);
    model_step();

    // Fixed select, then reselect.
    cycle(0, 3, 4'hF, D0, 1);
    cycle(0, 1, 4'hF, D0, 1);

    // Backpressure: load ch3, stall three cycles, then resume with fresh data.
    cycle(0, 3, 4'hF, D0, 1);
    repeat (3) cycle(0, 3, 4'hF, D0, 0);
    cycle(0, 0, 4'hF, 32'hA4A3A2A1, 1);
    cycle(0, 2, 4'hF, 32'hB4B3B2B1, 1);
    cycle(0, 2, 4'hF, 32'hC4C3C2C1, 1);
    cycle(0, 2, 4'h0, 32'hD4D3D2D1, 1);

`ifdef STREAM_MUX_RR_EN
    // Round-robin fairness, then alternating subset.
    repeat (8) cycle(1, 0, 4'hF, D0, 1);
    repeat (4) cycle(1, 0, 4'b1010, D0, 1);
`endif

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 1)), $urandom_range(0, 3), 4'($urandom),
            $urandom, ($urandom_range(0, 3) != 0));
    end

    // Reset while stalled on a valid word.
    cycle(0, 1, 4'hF, D0, 1);
    cycle(0, 1, 4'hF, D0, 0);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    m_occ = 0; m_last = N - 1; m_sel_err = 0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    mode = RR; sel = 2'd0; in_valid = 4'hF; in_data = 32'h5A6B7C8D; out_ready = 1'b1;
    #1;
    model_step();
    repeat (4) cycle(RR, 0, 4'hF, 32'h5A6B7C8D, 1);

    // Three-channel instance: out-of-range select.
    cycle(0, 0, 4'h0, D0, 1);
    sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 24'h332211;
    #1;
    chk("n3_oob_in_ready", 32'(in_ready3), 32'd0);
    cycle(0, 0, 4'h0, D0, 1);
    chk("n3_sel_err_set", 32'(sel_err3), 32'd1);
    chk("n3_no_xfer", 32'(out_valid3), 32'd0);
    sel3 = 2'd0;
    #1;
    chk("n3_in_ready", 32'(in_ready3), 32'h1);
    cycle(0, 0, 4'h0, D0, 1);
    chk("n3_sel_err_clr", 32'(sel_err3), 32'd0);
    chk("n3_out_valid", 32'(out_valid3), 32'd1);
    chk("n3_out_data", 32'(out_data3), 32'h11);
    chk("n3_out_ch", 32'(out_ch3), 32'd0);

    repeat (3) cycle(0, 0, 4'h0, D0, 1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
